// File: rtl/zeroriscy_data_axil_bridge_pkg.sv
// Shared types and constants for the zero-riscy data-side AXI4-Lite bridge.
package zeroriscy_axil_pkg;

  // Bridge FSM states: write path WRITE->BRESP, read path AREQ->RDATA, both end in RESP.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_BRESP = 3'd2,
    ST_AREQ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } bridge_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/zeroriscy_data_axil_bridge_if.sv
// AXI4-Lite bus bundle between the bridge (master) and the interconnect (slave).
interface zeroriscy_data_axil_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [31:0]               wdata;
  logic [3:0]                wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [31:0]               rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/zeroriscy_axil_wr_tracker.sv
// Tracks completion of the independent AW and W phases of one AXI-Lite write.
module zeroriscy_axil_wr_tracker (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic aw_hs_i,
  input  logic w_hs_i,
  output logic aw_done_o,
  output logic w_done_o,
  output logic wr_phase_done_o
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  // Next-state of the done flags: clear at grant, set on each phase's handshake.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (clr_i) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs_i) aw_done_d = 1'b1;
      if (w_hs_i)  w_done_d  = 1'b1;
    end
  end

  // Flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign aw_done_o = aw_done_q;
  assign w_done_o  = w_done_q;
  // A phase counts as done if it finished earlier or is finishing this cycle.
  assign wr_phase_done_o = (aw_done_q | aw_hs_i) & (w_done_q | w_hs_i);

endmodule

// File: rtl/zeroriscy_data_axil_bridge.sv
// LSU req/gnt/rvalid to AXI4-Lite master, one outstanding transaction.
module zeroriscy_data_axil_bridge
  import zeroriscy_axil_pkg::*;
#(
  parameter int         AXI_ADDR_WIDTH = 32,
  parameter bit         ALIGN_ADDR     = 1'b1,
  parameter logic [2:0] AXI_PROT       = AXI_PROT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  zeroriscy_data_axil_bridge_if.master m_axi,
  output logic        busy_o
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic gnt_c, wr_clr;
  logic aw_done, w_done, wr_phase_done;
  logic awvalid, wvalid, aw_hs, w_hs;
  logic [31:0] addr_aligned;
  logic [AXI_ADDR_WIDTH-1:0] axi_addr;

  // AW/W valids decode only registered state, so they hold until their handshake.
  assign awvalid = (state_q == ST_WRITE) & ~aw_done;
  assign wvalid  = (state_q == ST_WRITE) & ~w_done;
  assign aw_hs   = awvalid & m_axi.awready;
  assign w_hs    = wvalid & m_axi.wready;

  zeroriscy_axil_wr_tracker u_wr_tracker (
    .clk             (clk),
    .rst             (rst),
    .clr_i           (wr_clr),
    .aw_hs_i         (aw_hs),
    .w_hs_i          (w_hs),
    .aw_done_o       (aw_done),
    .w_done_o        (w_done),
    .wr_phase_done_o (wr_phase_done)
  );

  // FSM next-state, request capture and per-state handshake outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    wr_clr        = 1'b0;
    gnt_c         = 1'b0;
    data_rvalid_o = 1'b0;
    m_axi.bready  = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_c = data_req_i;
        if (data_req_i) begin
          addr_d  = data_addr_i;
          be_d    = data_be_i;
          wdata_d = data_wdata_i;
          wr_clr  = 1'b1;
          state_d = data_we_i ? ST_WRITE : ST_AREQ;
        end
      end
      ST_WRITE: begin
        if (wr_phase_done) state_d = ST_BRESP;
      end
      ST_BRESP: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          err_d   = resp_is_err(m_axi.bresp);
          state_d = ST_RESP;
        end
      end
      ST_AREQ: begin
        m_axi.arvalid = 1'b1;
        if (m_axi.arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          err_d   = resp_is_err(m_axi.rresp);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        data_rvalid_o = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Grant is masked while reset is held so the core never sees a grant it cannot complete.
  assign data_gnt_o   = gnt_c & ~rst;
  assign data_err_o   = data_rvalid_o & err_q;
  assign data_rdata_o = rdata_q;
  assign busy_o       = (state_q != ST_IDLE);

  assign addr_aligned = ALIGN_ADDR ? {addr_q[31:2], 2'b00} : addr_q;

  // Fit the 32-bit core address onto the AXI address width.
  generate
    if (AXI_ADDR_WIDTH > 32) begin : g_addr_ext
      assign axi_addr = {{(AXI_ADDR_WIDTH-32){1'b0}}, addr_aligned};
    end else begin : g_addr_trunc
      assign axi_addr = addr_aligned[AXI_ADDR_WIDTH-1:0];
    end
  endgenerate

  assign m_axi.awaddr  = axi_addr;
  assign m_axi.araddr  = axi_addr;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = be_q;

endmodule

// File: tb/tb_zeroriscy_data_axil_bridge.sv
// Self-checking bench: vector table, directed corner cases and random traffic.
module tb_zeroriscy_data_axil_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        data_req_i, data_we_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o, busy_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i;

  zeroriscy_data_axil_bridge_if #(.AXI_ADDR_WIDTH(32)) axi ();

  zeroriscy_data_axil_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_err_o    (data_err_o),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .m_axi         (axi),
    .busy_o        (busy_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Slave configuration (per transaction).
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  // Observations made by the slave/monitor.
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_vcyc = 0, w_vcyc = 0;
  int aw_cyc, w_cyc;
  logic [31:0] aw_addr_s, ar_addr_s, wdata_s;
  logic [3:0]  wstrb_s;
  int pulse_cnt = 0;
  int pulse_q[$];
  logic pulse_err;
  logic [31:0] pulse_rdata;

  // AXI-Lite slave with programmable ready/valid delays, plus core-side monitor.
  initial begin
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit aw_got, w_got, b_pend, r_pend;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.rvalid = 0;
      end else begin
        if (r_pend) begin
          axi.rvalid = (r_wait >= r_dly);
          axi.rdata  = axi.rvalid ? s_rdata : 32'h0BAD_F00D;
          axi.rresp  = s_rresp;
          r_wait++;
          if (axi.rvalid && axi.rready) begin r_cnt++; r_pend = 0; end
        end else begin
          axi.rvalid = 0;
          axi.rdata  = 32'h0BAD_F00D;
        end
        if (b_pend) begin
          axi.bvalid = (b_wait >= b_dly);
          axi.bresp  = s_bresp;
          b_wait++;
          if (axi.bvalid && axi.bready) begin b_cnt++; b_pend = 0; end
        end else begin
          axi.bvalid = 0;
        end
        if (axi.awvalid) begin
          aw_vcyc++;
          axi.awready = (aw_wait >= aw_dly);
          aw_wait++;
          if (axi.awready) begin aw_cnt++; aw_cyc = cyc; aw_addr_s = axi.awaddr; aw_got = 1; end
        end else begin
          axi.awready = 0; aw_wait = 0;
        end
        if (axi.wvalid) begin
          w_vcyc++;
          axi.wready = (w_wait >= w_dly);
          w_wait++;
          if (axi.wready) begin w_cnt++; w_cyc = cyc; wdata_s = axi.wdata; wstrb_s = axi.wstrb; w_got = 1; end
        end else begin
          axi.wready = 0; w_wait = 0;
        end
        if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
        if (axi.arvalid) begin
          axi.arready = (ar_wait >= ar_dly);
          ar_wait++;
          if (axi.arready) begin ar_cnt++; ar_addr_s = axi.araddr; r_pend = 1; r_wait = 0; end
        end else begin
          axi.arready = 0; ar_wait = 0;
        end
        if (data_rvalid_o) begin
          pulse_cnt++;
          pulse_q.push_back(cyc);
          pulse_err   = data_err_o;
          pulse_rdata = data_rdata_o;
        end
      end
    end
  end

  // Reference model state: the core sees the most recent load word.
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          awd, wd, bd, ard, rd;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    logic        err;
  } vec_t;

  // One complete transaction, checked against the expected latency/err/data.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input int awd, input int wd, input int bd, input int ard, input int rd,
                        input logic [1:0] resp, input logic [31:0] rdata,
                        input int exp_lat, input logic exp_err);
    int t0, k, p0, aw0, w0, b0, ar0, r0, awv0, wv0;
    logic [31:0] exp_addr;
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    s_bresp = resp; s_rresp = resp; s_rdata = rdata;
    exp_addr = addr & 32'hFFFF_FFFC;
    p0 = pulse_cnt; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    awv0 = aw_vcyc; wv0 = w_vcyc;
    @(negedge clk);
    data_req_i = 1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wdata;
    #1;
    chk({tag, "_gnt"}, data_gnt_o, 1);
    t0 = cyc;
    @(posedge clk); #1;
    data_req_i = 0; data_addr_i = $urandom; data_wdata_i = $urandom; data_be_i = 4'hF;
    data_we_i = ~we;
    chk({tag, "_busy"}, busy_o, 1);
    k = 0;
    while (pulse_cnt == p0 && k < 60) begin
      @(posedge clk); #1; k++;
    end
    if (pulse_cnt == p0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      if (!we) last_rd = rdata;
      chk({tag, "_lat"}, pulse_q[$] - t0, exp_lat);
      chk({tag, "_err"}, pulse_err, exp_err);
      chk({tag, "_rdata"}, pulse_rdata, last_rd);
      chk({tag, "_pulse1"}, data_rvalid_o, 0);
      chk({tag, "_idle"}, busy_o, 0);
      if (we) begin
        chk({tag, "_beats"}, {aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0}, {32'd1, 32'd1, 32'd1, 32'd0} & 64'hFFFFFFFF_FFFFFFFF);
        chk({tag, "_awaddr"}, aw_addr_s, exp_addr);
        chk({tag, "_wdata"}, wdata_s, wdata);
        chk({tag, "_wstrb"}, wstrb_s, be);
        chk({tag, "_awvcyc"}, aw_vcyc - awv0, awd + 1);
        chk({tag, "_wvcyc"}, w_vcyc - wv0, wd + 1);
        chk({tag, "_awcyc"}, aw_cyc - t0, awd + 1);
        chk({tag, "_wcyc"}, w_cyc - t0, wd + 1);
      end else begin
        chk({tag, "_rbeats"}, ar_cnt - ar0, 1);
        chk({tag, "_rbeat"}, r_cnt - r0, 1);
        chk({tag, "_nowr"}, (aw_cnt - aw0) + (w_cnt - w0), 0);
        chk({tag, "_araddr"}, ar_addr_s, exp_addr);
      end
    end
    $display("txn %s we=%0d addr=%h lat_exp=%0d err_exp=%0d rdata=%h", tag, we, addr, exp_lat, exp_err, data_rdata_o);
  endtask

  vec_t vecs[7];

  initial begin
    logic [7:0] gv;
    int t0, p0, ar0, maxd, lat;
    logic we;
    logic [1:0] resp;

    vecs[0] = '{0, 32'h0000_1006, 4'hF, 32'h0,         0, 0, 0, 0, 0, 2'b00, 32'hCAFE_BABE, 3, 0};
    vecs[1] = '{1, 32'h0000_0020, 4'hC, 32'h1234_1234, 0, 3, 0, 0, 0, 2'b00, 32'h0,         6, 0};
    vecs[2] = '{1, 32'h0000_0044, 4'hF, 32'hA5A5_5A5A, 2, 0, 0, 0, 0, 2'b00, 32'h0,         5, 0};
    vecs[3] = '{0, 32'h0000_0080, 4'hF, 32'h0,         0, 0, 0, 0, 0, 2'b10, 32'h5555_AAAA, 3, 1};
    vecs[4] = '{1, 32'h0000_0084, 4'h3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'b11, 32'h0,         3, 1};
    vecs[5] = '{1, 32'h0000_0103, 4'h0, 32'h0F0F_0F0F, 0, 0, 2, 0, 0, 2'b01, 32'h0,         5, 0};
    vecs[6] = '{0, 32'h7FFF_FFFF, 4'hF, 32'h0,         0, 0, 0, 1, 2, 2'b01, 32'h1357_9BDF, 6, 0};

    rst = 1; data_req_i = 1; data_we_i = 0; data_addr_i = 0; data_be_i = 0; data_wdata_i = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    s_bresp = 0; s_rresp = 0; s_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {data_gnt_o, data_rvalid_o, data_err_o, busy_o,
                     axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    chk("rst_rdata", data_rdata_o, 0);
    $display("reset state checked");
    @(negedge clk); data_req_i = 0; rst = 0;

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      do_txn($sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
             vecs[i].awd, vecs[i].wd, vecs[i].bd, vecs[i].ard, vecs[i].rd,
             vecs[i].resp, vecs[i].rdata, vecs[i].lat, vecs[i].err);
    end

    // Back-to-back loads with req held high.
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    s_rresp = 2'b00; s_rdata = 32'h1111_2222;
    p0 = pulse_q.size();
    @(negedge clk);
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h200;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) data_addr_i = 32'h300;
      if (k == 4) s_rdata = 32'h3333_4444;
      if (k == 5) data_req_i = 0;
      #1;
      gv[k] = data_gnt_o;
    end
    @(posedge clk); #1;
    chk("b2b_gnt", gv, 8'b0001_0001);
    chk("b2b_npulse", pulse_q.size() - p0, 2);
    if (pulse_q.size() - p0 == 2) begin
      chk("b2b_rv1", pulse_q[p0] - t0, 3);
      chk("b2b_rv2", pulse_q[p0 + 1] - t0, 7);
    end
    chk("b2b_araddr2", ar_addr_s, 32'h300);
    chk("b2b_rdata", data_rdata_o, 32'h3333_4444);
    last_rd = 32'h3333_4444;
    $display("txn b2b gnt=%b rdata=%h", gv, data_rdata_o);

    // Reset while waiting for read data.
    r_dly = 6; s_rdata = 32'h7777_8888;
    p0 = pulse_cnt; ar0 = ar_cnt;
    @(negedge clk);
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h400;
    @(posedge clk); #1;
    data_req_i = 0;
    @(posedge clk); #1;
    chk("mrst_ar_accepted", ar_cnt - ar0, 1);
    chk("mrst_rready", axi.rready, 1);
    data_req_i = 1;
    rst = 1;
    #1;
    chk("mrst_outs", {data_gnt_o, data_rvalid_o, data_err_o, busy_o,
                      axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    chk("mrst_rdata", data_rdata_o, 0);
    last_rd = 0;
    @(negedge clk); data_req_i = 0;
    @(negedge clk); rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_nopulse", pulse_cnt - p0, 0);
    $display("txn midreset rdata=%h", data_rdata_o);
    do_txn("post_rst", 0, 32'h0000_0408, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h2468_ACE0, 3, 0);

    // Random traffic against the latency/response model.
    for (int i = 0; i < 40; i++) begin
      int awd, wd, bd, ard, rd;
      awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      ard = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1));
      resp = 2'($urandom_range(0, 3));
      maxd = (awd > wd) ? awd : wd;
      lat = we ? (3 + maxd + bd) : (3 + ard + rd);
      do_txn($sformatf("r%0d", i), we, $urandom, 4'($urandom_range(0, 15)), $urandom,
             awd, wd, bd, ard, rd, resp, $urandom, lat, (resp >= 2'd2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zeroriscy_data_axil_bridge.md
Name: zeroriscy_data_axil_bridge

Overview:
Converts the core's data-side req/gnt/rvalid interface, driven by the load/store unit, into an AXI4-Lite master. It sits directly downstream of the LSU, between it and the system interconnect. It supports exactly one outstanding transaction, presents the captured response to the LSU as a single-cycle rvalid pulse, and maps AXI error responses onto the core error signal.

Parameters:
AXI_ADDR_WIDTH, 32, width of the AXI address buses; core address is 32 b, zero-extended or truncated to fit.
ALIGN_ADDR, 1, when 1 force awaddr/araddr[1:0] to 2'b00; strobes carry the byte lanes.
AXI_PROT, 3'b000, constant driven on awprot/arprot.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
data_req_i  in  1  request from LSU
data_gnt_o  out  1  grant to LSU
data_rvalid_o  out  1  response valid, 1-cycle pulse
data_err_o  out  1  response error, qualified by data_rvalid_o
data_addr_i  in  32  byte address
data_we_i  in  1  1 = store
data_be_i  in  4  byte enables
data_wdata_i  in  32  store data, lane-replicated by LSU
data_rdata_o  out  32  raw load word, no alignment applied
m_awaddr_o  out  AXI_ADDR_WIDTH  write address
m_awprot_o  out  3  write protection
m_awvalid_o  out  1  write address valid
m_awready_i  in  1  write address ready
m_wdata_o  out  32  write data
m_wstrb_o  out  4  write strobes
m_wvalid_o  out  1  write data valid
m_wready_i  in  1  write data ready
m_bresp_i  in  2  write response
m_bvalid_i  in  1  write response valid
m_bready_o  out  1  write response ready
m_araddr_o  out  AXI_ADDR_WIDTH  read address
m_arprot_o  out  3  read protection
m_arvalid_o  out  1  read address valid
m_arready_i  in  1  read address ready
m_rdata_i  in  32  read data
m_rresp_i  in  2  read response
m_rvalid_i  in  1  read data valid
m_rready_o  out  1  read data ready
busy_o  out  1  state != IDLE

Behaviour:
- Reset, asynchronous (rst=1): state IDLE. All valid/ready/gnt/rvalid/err outputs 0. Address, data and rdata registers 0. busy_o 0.
- States: IDLE, WRITE (AW/W phase), BRESP, AREQ, RDATA, RESP.
- IDLE
  - data_gnt_o = data_req_i, combinational.
  - On req&gnt: latch addr, we, be, wdata into request registers; clear aw_done and w_done.
  - Next state WRITE if we, else AREQ.
  - No AXI valid is asserted in the grant cycle.
- WRITE
  - m_awvalid_o = !aw_done; m_wvalid_o = !w_done. Both are driven from registers and stay stable until their handshake.
  - Set aw_done on awvalid&awready; set w_done on wvalid&wready. Either order, or the same cycle, is legal.
  - When both phases are complete (including completion in the current cycle), go to BRESP. The earliest transition is 1 cycle after entry.
- BRESP: m_bready_o = 1. On bvalid: err_q = bresp[1] (SLVERR/DECERR -> 1, OKAY/EXOKAY -> 0); rdata_q unchanged; go to RESP.
- AREQ: m_arvalid_o = 1, stable; on arready go to RDATA.
- RDATA: m_rready_o = 1. On rvalid: rdata_q = m_rdata_i, err_q = rresp[1]; go to RESP.
- RESP
  - data_rvalid_o = 1 and data_err_o = err_q for exactly one cycle; then IDLE.
  - data_gnt_o = 0 in RESP. A new request is granted in the following IDLE cycle, so the LSU sits in WAIT_GNT for one cycle.
- data_rdata_o = rdata_q at all times. It holds the last load value, and holds across stores.
- Minimum latencies with always-ready slaves, grant cycle = T0:
  - read: AR handshake T1, R handshake T2, data_rvalid_o T3.
  - write: AW+W handshake T1, B handshake T2, data_rvalid_o T3.
- data_req_i deasserting or changing while not in IDLE is ignored; the latched copy drives AXI.
- Address/strobe: awaddr/araddr = latched addr with [1:0] zeroed when ALIGN_ADDR=1. wstrb = latched be. be=4'b0000 on a store is forwarded unchanged.
- Reset asserted mid-transaction: immediate return to IDLE with all valids dropped. The interconnect must be reset in the same domain; no completion is reported to the core.

Decomposition:
- Package zeroriscy_axil_pkg:
  - state enum bridge_state_e
  - AXI response localparams RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
  - PROT default
- One sub-module, zeroriscy_axil_wr_tracker, holds the aw_done/w_done flags and produces wr_phase_done. All remaining logic is flat in the bridge.

Test Plan:
- Read, always-ready slave: req addr=0x0000_1006, we=0, slave rdata=0xCAFE_BABE, rresp=OKAY.
  - Expect araddr=0x0000_1004, data_rvalid_o pulse at T3, data_rdata_o=0xCAFE_BABE, data_err_o=0.
- Store, wready 3 cycles after awready: addr=0x20, be=4'b1100, wdata=0x1234_1234.
  - Expect awvalid to drop after its handshake, wvalid held 3 extra cycles, wstrb=4'b1100, then bready, then a single rvalid pulse.
- W handshake before AW (awready delayed 2 cycles after wready).
  - Expect wvalid deasserted while awvalid is still held, BRESP entered only after AW completes, no duplicate W beat.
- Error mapping: read with rresp=2'b10, then write with bresp=2'b11.
  - Expect data_err_o=1 on both rvalid pulses; data_rdata_o updated by the read only.
- Back-to-back: data_req_i held high across two loads.
  - Expect gnt at T0, gnt low in RESP (T3), second gnt at T4, second rvalid at T7.
- Reset mid-read: assert rst while in RDATA with arvalid already accepted.
  - Expect all outputs 0 immediately, state IDLE, no data_rvalid_o pulse; the next request is granted normally.
